// File: rtl/trng_pkg.sv
// Shared register map, bit positions and bus FSM encoding for the TRNG word buffer.
package trng_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 2;

  localparam logic [OFF_W-1:0] REG_DATA   = 2'd0;
  localparam logic [OFF_W-1:0] REG_STATUS = 2'd1;
  localparam logic [OFF_W-1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_HEALTH    = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_CLEAR  = 2;

  localparam int unsigned RCT_RUN_W = 4;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: flags a run of RCT_CUTOFF identical words.
// Only instantiated when TRNG_HEALTH_RCT_EN is defined.
module trng_rct
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] word,
  input  logic              strobe,
  input  logic              clear,
  output logic              fail_pulse
);

  logic [DATA_W-1:0]    r_prev;
  logic [RCT_RUN_W-1:0] r_run;
  logic [RCT_RUN_W-1:0] w_run_nxt;
  logic                 w_same;

  // A zero run means no previous word has been tested yet.
  assign w_same = (r_run != '0) && (word == r_prev);

  always_comb begin
    w_run_nxt = RCT_RUN_W'(1);
    if (w_same) begin
      if (r_run >= RCT_RUN_W'(RCT_CUTOFF)) w_run_nxt = RCT_RUN_W'(RCT_CUTOFF);
      else                                 w_run_nxt = r_run + RCT_RUN_W'(1);
    end
  end

  assign fail_pulse = strobe && !clear && (w_run_nxt == RCT_RUN_W'(RCT_CUTOFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_run  <= '0;
    end else if (clear) begin
      r_run <= '0;
    end else if (strobe) begin
      r_prev <= word;
      r_run  <= w_run_nxt;
    end
  end

endmodule

// File: rtl/trng_word_buffer.sv
// TRNG word FIFO exposed on the PicoRV32 native bus (DATA/STATUS/CTRL registers).
// Optional repetition-count health test built when TRNG_HEALTH_RCT_EN is defined.
module trng_word_buffer
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int unsigned RCT_CUTOFF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rng_data,
  input  logic        rng_valid,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        health_fail
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bus_state_e r_state;
  bus_state_e w_state_nxt;

  logic              r_mem_ready;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              w_ready_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic [DATA_W-1:0] w_rdata_mux;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_enable;
  logic              r_overflow;

  logic             w_sel;
  logic [OFF_W-1:0] w_off;
  logic             w_is_read;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_ctrl_wr;
  logic             w_flush_req;
  logic             w_clear;
  logic             w_strobe;
  logic             w_trip;
  logic             w_hf;
  logic             w_push_try;
  logic             w_push;
  logic             w_ovf_evt;
  logic             w_flush;
  logic             w_unused;

  // The !mem_ready term keeps a still-asserted request from being answered twice.
  assign w_sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !r_mem_ready;
  assign w_off     = mem_addr[3:2];
  assign w_is_read = (mem_wstrb == 4'h0);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));

  assign w_pop       = w_sel && w_is_read && (w_off == REG_DATA) && !w_empty;
  assign w_ctrl_wr   = w_sel && (w_off == REG_CTRL) && mem_wstrb[0];
  assign w_flush_req = w_ctrl_wr && mem_wdata[CTRL_FLUSH];
  assign w_clear     = w_ctrl_wr && mem_wdata[CTRL_CLEAR];
  assign w_strobe    = rng_valid && r_enable;

`ifdef TRNG_HEALTH_RCT_EN
  logic r_health_fail;

  trng_rct #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk        (clk),
    .rst        (rst),
    .word       (rng_data),
    .strobe     (w_strobe),
    .clear      (w_clear),
    .fail_pulse (w_trip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_health_fail <= 1'b0;
    else     r_health_fail <= (r_health_fail && !w_clear) || w_trip;
  end

  assign w_hf        = r_health_fail;
  assign health_fail = r_health_fail;
  assign w_unused    = ^{1'b0, mem_addr[1:0], mem_wdata[31:3]};
`else
  assign w_trip      = 1'b0;
  assign w_hf        = 1'b0;
  assign health_fail = 1'b0;
  assign w_unused    = ^{1'b0, mem_addr[1:0], mem_wdata[31:3], RCT_CUTOFF[0]};
`endif

  // A tripping word is never stored; a trip also empties the FIFO.
  assign w_push_try = w_strobe && !w_hf && !w_trip;
  assign w_push     = w_push_try && !w_full;
  assign w_ovf_evt  = w_push_try && w_full;
  assign w_flush    = w_flush_req || w_trip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) r_mem[r_wr_ptr] <= rng_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable   <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_enable <= mem_wdata[CTRL_ENABLE];
      r_overflow <= (r_overflow && !w_clear) || w_ovf_evt;
    end
  end

  // Read view sampled at the sel cycle, before that cycle's push/pop.
  always_comb begin
    w_rdata_mux = '0;
    case (w_off)
      REG_DATA: begin
        if (!w_empty) w_rdata_mux = r_mem[r_rd_ptr];
      end
      REG_STATUS: begin
        w_rdata_mux[ST_NOT_EMPTY] = !w_empty;
        w_rdata_mux[ST_FULL]      = w_full;
        w_rdata_mux[ST_HEALTH]    = w_hf;
        w_rdata_mux[ST_OVERFLOW]  = r_overflow;
        w_rdata_mux[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(r_count);
      end
      REG_CTRL: begin
        w_rdata_mux[CTRL_ENABLE] = r_enable;
      end
      default: w_rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BUS_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUS_IDLE: if (w_sel) w_state_nxt = BUS_RESP;
      BUS_RESP: w_state_nxt = BUS_IDLE;
      default:  w_state_nxt = BUS_IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = 1'b0;
    w_rdata_nxt = '0;
    case (r_state)
      BUS_IDLE: begin
        if (w_sel) begin
          w_ready_nxt = 1'b1;
          if (w_is_read) w_rdata_nxt = w_rdata_mux;
        end
      end
      default: begin
        w_ready_nxt = 1'b0;
        w_rdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
    end else begin
      r_mem_ready <= w_ready_nxt;
      r_mem_rdata <= w_rdata_nxt;
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_trng_word_buffer.sv
// Self-checking bench for trng_word_buffer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_trng_word_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0200_0000;
`ifdef TRNG_HEALTH_RCT_EN
  localparam int          CUT   = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rng_data = '0;
  logic        rng_valid = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        health_fail;

  int n_tests = 0;
  int n_fail  = 0;

  trng_word_buffer #(
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .RCT_CUTOFF (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rng_data    (rng_data),
    .rng_valid   (rng_valid),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model state
  logic [31:0] q[$];
  bit m_en, m_ovf, m_hf;
`ifdef TRNG_HEALTH_RCT_EN
  int          m_run;
  logic [31:0] m_prev;
`endif

  task automatic m_reset();
    q.delete();
    m_en = 1; m_ovf = 0; m_hf = 0;
`ifdef TRNG_HEALTH_RCT_EN
    m_run = 0; m_prev = '0;
`endif
  endtask

  // One clock of the reference model; returns the expected read data.
  task automatic m_cycle(input bit bus, input logic [1:0] off, input logic [3:0] strb,
                         input logic [31:0] wd, input bit stb, input logic [31:0] w,
                         output logic [31:0] rd);
    bit ctrl_wr, clr, fl, trip, ovf_evt;
    int pre;
    rd = '0;
    pre = q.size();
    if (bus && strb == 4'h0) begin
      case (off)
        2'd0: if (pre != 0) rd = q.pop_front();
        2'd1: rd = {16'h0, 8'(pre), 4'h0, m_ovf, m_hf, (pre == DEPTH), (pre != 0)};
        2'd2: rd = {31'h0, m_en};
        default: rd = '0;
      endcase
    end
    ctrl_wr = bus && (off == 2'd2) && strb[0];
    clr = ctrl_wr && wd[2];
    fl  = ctrl_wr && wd[1];
    trip = 0;
`ifdef TRNG_HEALTH_RCT_EN
    if (clr) m_run = 0;
    else if (stb && m_en) begin
      if (m_run != 0 && w == m_prev) m_run = (m_run + 1 > CUT) ? CUT : m_run + 1;
      else                           m_run = 1;
      m_prev = w;
      trip = (m_run == CUT);
    end
`endif
    ovf_evt = 0;
    if (stb && m_en && !m_hf && !trip) begin
      if (pre == DEPTH) ovf_evt = 1;
      else              q.push_back(w);
    end
    if (fl || trip) q.delete();
    m_hf  = (m_hf && !clr) || trip;
    m_ovf = (m_ovf && !clr) || ovf_evt;
    if (ctrl_wr) m_en = wd[0];
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One bus access (two cycles) and/or one strobe; checks latency, data and health flag.
  task automatic step(input bit bus, input logic [1:0] off, input logic [3:0] strb,
                      input logic [31:0] wd, input bit stb, input logic [31:0] w,
                      input bit chk, input logic [31:0] exp, input string nm);
    logic [31:0] mexp;
    mem_valid = bus;
    mem_addr  = BASE | {28'h0, off, 2'b00};
    mem_wstrb = bus ? strb : 4'h0;
    mem_wdata = wd;
    rng_valid = stb;
    rng_data  = w;
    m_cycle(bus, off, bus ? strb : 4'h0, wd, stb, w, mexp);
    @(posedge clk); #1;
    mem_valid = 0; rng_valid = 0; mem_wstrb = 4'h0;
    if (bus) begin
      check({nm, "_ready"}, {31'h0, mem_ready}, 32'h1);
      if (strb == 4'h0) begin
        check({nm, "_model"}, mem_rdata, mexp);
        if (chk) check(nm, mem_rdata, exp);
      end
      @(posedge clk); #1;
      check({nm, "_ready_drop"}, {31'h0, mem_ready}, 32'h0);
    end
    check({nm, "_health"}, {31'h0, health_fail}, {31'h0, m_hf});
  endtask

  typedef struct {
    bit          bus;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wd;
    bit          stb;
    logic [31:0] w;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v_s(input logic [31:0] w);
    return '{bus: 0, off: 2'd0, strb: 4'h0, wd: '0, stb: 1, w: w, chk: 0, exp: '0};
  endfunction
  function automatic vec_t v_r(input logic [1:0] off, input logic [31:0] exp);
    return '{bus: 1, off: off, strb: 4'h0, wd: '0, stb: 0, w: '0, chk: 1, exp: exp};
  endfunction
  function automatic vec_t v_rs(input logic [1:0] off, input logic [31:0] exp, input logic [31:0] w);
    return '{bus: 1, off: off, strb: 4'h0, wd: '0, stb: 1, w: w, chk: 1, exp: exp};
  endfunction
  function automatic vec_t v_w(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd);
    return '{bus: 1, off: off, strb: strb, wd: wd, stb: 0, w: '0, chk: 0, exp: '0};
  endfunction
  function automatic vec_t v_ws(input logic [1:0] off, input logic [31:0] wd, input logic [31:0] w);
    return '{bus: 1, off: off, strb: 4'hF, wd: wd, stb: 1, w: w, chk: 0, exp: '0};
  endfunction

  logic [31:0] pool [3];
  logic [31:0] rd_dummy;

  initial begin
    pool[0] = 32'h0000_5A5A; pool[1] = 32'hFFFF_0000; pool[2] = 32'h1234_5678;
    m_reset();

    // Reset values while rst is held
    #1;
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_health", {31'h0, health_fail}, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    // Directed vectors
    tbl.push_back(v_r(2'd1, 32'h0));
    tbl.push_back(v_r(2'd2, 32'h1));
    tbl.push_back(v_s(32'h11)); tbl.push_back(v_s(32'h22)); tbl.push_back(v_s(32'h33));
    tbl.push_back(v_r(2'd1, 32'h0000_0301));
    tbl.push_back(v_r(2'd0, 32'h11)); tbl.push_back(v_r(2'd0, 32'h22));
    tbl.push_back(v_r(2'd0, 32'h33)); tbl.push_back(v_r(2'd0, 32'h0));
    tbl.push_back(v_r(2'd1, 32'h0));
    tbl.push_back(v_r(2'd3, 32'h0));
    tbl.push_back(v_w(2'd0, 4'hF, 32'h1234));
    tbl.push_back(v_r(2'd1, 32'h0));
    tbl.push_back(v_s(32'hA1)); tbl.push_back(v_s(32'hA2));
    tbl.push_back(v_rs(2'd0, 32'hA1, 32'hA3));
    tbl.push_back(v_r(2'd1, 32'h0000_0201));
    tbl.push_back(v_r(2'd0, 32'hA2)); tbl.push_back(v_r(2'd0, 32'hA3));
    tbl.push_back(v_rs(2'd0, 32'h0, 32'hA4));
    tbl.push_back(v_r(2'd1, 32'h0000_0101));
    tbl.push_back(v_r(2'd0, 32'hA4));
    tbl.push_back(v_w(2'd2, 4'hF, 32'h0));
    tbl.push_back(v_s(32'hB1)); tbl.push_back(v_s(32'hB2)); tbl.push_back(v_s(32'hB3));
    tbl.push_back(v_r(2'd1, 32'h0));
    tbl.push_back(v_r(2'd2, 32'h0));
    tbl.push_back(v_w(2'd2, 4'h2, 32'h1));
    tbl.push_back(v_r(2'd2, 32'h0));
    tbl.push_back(v_w(2'd2, 4'h1, 32'h1));
    tbl.push_back(v_r(2'd2, 32'h1));
    tbl.push_back(v_s(32'hB4)); tbl.push_back(v_s(32'hB5));
    tbl.push_back(v_r(2'd1, 32'h0000_0201));
    tbl.push_back(v_ws(2'd2, 32'h3, 32'hB6));
    tbl.push_back(v_r(2'd1, 32'h0));
    tbl.push_back(v_r(2'd2, 32'h1));
    for (int i = 0; i < 9; i++) tbl.push_back(v_s(32'hC0 + 32'(i)));
    tbl.push_back(v_r(2'd1, 32'h0000_080B));
    for (int i = 0; i < 8; i++) tbl.push_back(v_r(2'd0, 32'hC0 + 32'(i)));
    tbl.push_back(v_r(2'd0, 32'h0));
    tbl.push_back(v_r(2'd1, 32'h0000_0008));
    tbl.push_back(v_w(2'd2, 4'hF, 32'h5));
    tbl.push_back(v_r(2'd1, 32'h0));
    tbl.push_back(v_r(2'd2, 32'h1));

    foreach (tbl[i])
      step(tbl[i].bus, tbl[i].off, tbl[i].strb, tbl[i].wd, tbl[i].stb, tbl[i].w,
           tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));

    // Repetition-count trip with two words already buffered
    step(0, 2'd0, 4'h0, '0, 1, 32'hE1, 0, '0, "rct_pre1");
    step(0, 2'd0, 4'h0, '0, 1, 32'hE2, 0, '0, "rct_pre2");
    for (int i = 0; i < 4; i++) step(0, 2'd0, 4'h0, '0, 1, 32'hDEAD_BEEF, 0, '0, "rct_rep");
`ifdef TRNG_HEALTH_RCT_EN
    check("rct_flag", {31'h0, health_fail}, 32'h1);
    step(1, 2'd1, 4'h0, '0, 0, '0, 1, 32'h0000_0004, "rct_status");
    step(0, 2'd0, 4'h0, '0, 1, 32'hF1, 0, '0, "rct_blk1");
    step(0, 2'd0, 4'h0, '0, 1, 32'hF2, 0, '0, "rct_blk2");
    step(1, 2'd1, 4'h0, '0, 0, '0, 1, 32'h0000_0004, "rct_blocked");
    step(1, 2'd2, 4'hF, 32'h5, 0, '0, 0, '0, "rct_clear");
    check("rct_cleared", {31'h0, health_fail}, 32'h0);
    step(0, 2'd0, 4'h0, '0, 1, 32'hF3, 0, '0, "rct_resume");
    step(1, 2'd1, 4'h0, '0, 0, '0, 1, 32'h0000_0101, "rct_resume_status");
    step(1, 2'd0, 4'h0, '0, 0, '0, 1, 32'hF3, "rct_resume_data");
`else
    step(1, 2'd1, 4'h0, '0, 0, '0, 1, 32'h0000_0601, "norct_status");
    check("norct_flag", {31'h0, health_fail}, 32'h0);
    step(1, 2'd2, 4'hF, 32'h3, 0, '0, 0, '0, "norct_flush");
    step(1, 2'd1, 4'h0, '0, 0, '0, 1, 32'h0, "norct_empty");
`endif

    // Requests outside the window must never be answered or take effect
    mem_valid = 1; mem_addr = BASE + 32'h18; mem_wstrb = 4'hF; mem_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("badaddr_ready", {31'h0, mem_ready}, 32'h0);
    end
    mem_valid = 0; mem_wstrb = 4'h0;
    step(1, 2'd2, 4'h0, '0, 0, '0, 1, 32'h1, "badaddr_ctrl");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit          bus, stb;
      logic [1:0]  off;
      logic [3:0]  strb;
      logic [31:0] wd;
      bus  = 1'($urandom_range(0, 1));
      stb  = 1'($urandom_range(0, 1));
      off  = 2'($urandom_range(0, 3));
      strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      wd   = {29'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 7) != 0)};
      step(bus, off, strb, wd, stb, pool[$urandom_range(0, 2)], 0, '0, "rand");
    end

    // Reset asserted during a response cycle
    for (int i = 0; i < 4; i++) step(0, 2'd0, 4'h0, '0, 1, 32'h77, 0, '0, "pre_rst");
    mem_valid = 1; mem_addr = BASE | 32'h4; mem_wstrb = 4'h0;
    m_cycle(1, 2'd1, 4'h0, '0, 0, '0, rd_dummy);
    @(posedge clk); #1;
    check("midrst_ready_before", {31'h0, mem_ready}, 32'h1);
    rst = 1; mem_valid = 0;
    #1;
    check("midrst_ready", {31'h0, mem_ready}, 32'h0);
    check("midrst_rdata", mem_rdata, 32'h0);
    check("midrst_health", {31'h0, health_fail}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("postrst_idle", {31'h0, mem_ready}, 32'h0);
    end
    step(1, 2'd1, 4'h0, '0, 0, '0, 1, 32'h0, "postrst_status");
    step(1, 2'd2, 4'h0, '0, 0, '0, 1, 32'h1, "postrst_ctrl");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_word_buffer.md
# trng_word_buffer

Consumes the 32-bit random words produced by the catching-RO TRNG stage (`data_out`/`data_valid`) and buffers them in a small FIFO. An optional repetition-count health test screens the words. The block exposes the FIFO to the PicoRV32 core as a memory-mapped peripheral on the native memory interface. Firmware pops random words by reading a DATA register and polls a STATUS register.

## Interface
- `DEPTH`, 8: FIFO depth in 32-bit words; power of two, 2..64.
- `BASE_ADDR`, 32'h0200_0000: peripheral base; bits [3:0] must be zero.
- `RCT_CUTOFF`, 4: number of consecutive identical words that trips the health test; 2..15.

- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `rng_data`  in  32  random word from the TRNG stage.
- `rng_valid`  in  1  one-cycle strobe; `rng_data` is valid.
- `mem_valid`  in  1  PicoRV32 bus request.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_ready`  out  1  one-cycle completion strobe.
- `mem_rdata`  out  32  read data, valid with `mem_ready`.
- `health_fail`  out  1  sticky health-test failure flag.

## Operation
- **Select:** `sel = mem_valid && mem_addr[31:4] == BASE_ADDR[31:4] && !mem_ready`.
- **Register map** (offset = `mem_addr[3:2]`):
  - 0: DATA (R). Pops the FIFO head. Empty returns 0 with no pop. Writes are ignored.
  - 1: STATUS (R).
    - bit0: not-empty.
    - bit1: full.
    - bit2: `health_fail`.
    - bit3: overflow, sticky.
    - [15:8]: occupancy count.
    - Other bits read 0.
  - 2: CTRL (R/W; only `mem_wstrb[0]` matters).
    - bit0: enable.
    - bit1: flush, self-clearing and reads 0.
    - bit2: clear-errors, self-clearing and reads 0.
  - 3: reads 0, writes ignored.
- **Bus FSM:** IDLE → RESP on `sel`. RESP lasts exactly one cycle, drives `mem_ready=1`, then returns to IDLE. The access side effects (pop, CTRL write) take effect at the `sel` cycle.
- **Push:** when `rng_valid && enable && !health_fail`:
  - not full: the word is written.
  - full: the word is dropped and overflow is set.
- **Simultaneous push and pop:** both happen and count is unchanged. A pop on an empty FIFO is not satisfied by the word being pushed in the same cycle; it returns 0.
- **Flush:** resets pointers and count to 0. It wins over a same-cycle push.
- **Clear-errors:** clears overflow and `health_fail`, and resets the RCT run counter.
- **Health (RCT):** every `rng_valid` word while enabled is compared with the previous tested word.
  - Equal: run++. Different: run = 1.
  - When run reaches `RCT_CUTOFF`, `health_fail` sets and the FIFO is flushed in the same cycle.
  - A tripping word is never pushed.
  - Pushes stay blocked until clear-errors.
- **Arithmetic:** pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. Count is log2(`DEPTH`)+1 bits, saturating by construction.

## Timing
- **Reset values:**
  - `mem_ready`=0, `mem_rdata`=0, `health_fail`=0.
  - FIFO empty, overflow=0, enable=1, RCT run=0, FSM=IDLE.
- **Bus latency:** `mem_ready` and `mem_rdata` are registered and appear the cycle after `sel`, giving one wait state. The `!mem_ready` term in `sel` prevents a second response to the same request.
- **Push visibility:** a word strobed at cycle N is in the FIFO at N+1 and readable by a request selected at N+1 or later.
- **STATUS timing:** STATUS reflects state at the `sel` cycle, before that cycle's push/pop.
- **Reset mid-transaction:** `mem_ready` is forced low immediately, and the pending request is answered only after it is re-issued.

## Configuration
- `TRNG_HEALTH_RCT_EN`:
  - **Defined:** the RCT logic above is built.
  - **Undefined:** no comparator or run counter. `health_fail` is tied to 0, STATUS bit2 reads 0, and pushes depend only on enable and full. Clear-errors still clears overflow.

## Structure
- **Package `trng_pkg`:** register offsets (`REG_DATA`, `REG_STATUS`, `REG_CTRL`), STATUS/CTRL bit-position constants, and bus FSM state encoding.
- **Sub-module `trng_rct`:** holds the previous-word register and run counter. Inputs: `clk`, `rst`, `word`, `strobe`, `clear`. Output: `fail_pulse`. It is instantiated only under `TRNG_HEALTH_RCT_EN`.

## Test plan
1. **Push and readback:** reset, then push 3 words 0x11,0x22,0x33 → STATUS reads 0x0000_0301. Three DATA reads return 0x11,0x22,0x33, each with `mem_ready` one cycle after request. A fourth read returns 0 and STATUS reads 0x0.
2. **Overflow:** push 9 distinct words with `DEPTH`=8 → STATUS = 0x0000_080B (full, not-empty, overflow). The first 8 words read back in order and the 9th is lost. Write CTRL=0x5 → overflow clears and enable stays set.
3. **RCT trip:** push 0xDEADBEEF four times (`RCT_CUTOFF`=4) with 2 other words buffered before → `health_fail`=1 and the FIFO is empty. Further distinct pushes are ignored. CTRL=0x5 clears the flag and pushes resume.
4. **Simultaneous push and pop:** with count 2, a DATA read is selected in the same cycle as `rng_valid` → the head word is returned and STATUS count is still 2.
5. **Disable and flush:** write CTRL=0x0 and strobe 3 words → count stays 0. Re-enable, push 2 words, then write CTRL=0x3 concurrently with a push → count 0.
6. **Reset mid-request:** assert `rst` during a RESP cycle → `mem_ready` drops immediately and all outputs return to reset values.
